// File: rtl/ex_stage.sv
// RV64I+Zba execute stage: operand forwarding, ALU, branch/jump resolution and the EM pipeline register.
// Optional branch statistics counters are compiled in when EX_PERF_CNT_EN is defined.
module ex_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_M,
  input  logic            flush_M,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] ImmExt_E,
  input  logic [4:0]      Rd_E,
  input  logic [6:0]      op_E,
  input  logic            RegWrite_E,
  input  logic            MemWrite_E,
  input  logic            ALUSrc_E,
  input  logic            Branch_E,
  input  logic            Jump_E,
  input  logic            is_jalr_E,
  input  logic [1:0]      ResultSrc_E,
  input  logic [4:0]      ALUControl_E,
  input  logic [2:0]      funct3_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] Result_W,
`ifdef EX_PERF_CNT_EN
  input  logic            perf_clr,
  output logic [31:0]     br_count,
  output logic [31:0]     br_taken_count,
`endif
  output logic            PCSrc_E,
  output logic [XLEN-1:0] PCTarget_E,
  output logic [XLEN-1:0] ALUResult_M,
  output logic [XLEN-1:0] WriteData_M,
  output logic [XLEN-1:0] PCPlus4_M,
  output logic [4:0]      Rd_M,
  output logic            RegWrite_M,
  output logic            MemWrite_M,
  output logic [1:0]      ResultSrc_M,
  output logic [2:0]      funct3_M
);

  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [XLEN-1:0] alu_result_q, write_data_q, pc_plus4_q;
  logic [4:0]      rd_q;
  logic            reg_write_q, mem_write_q;
  logic [1:0]      result_src_q;
  logic [2:0]      funct3_q;

  logic [XLEN-1:0] rd1_fwd, rd2_fwd, src_a, src_b, alu_result;
  logic            branch_cond;

  // Forward select 11 falls through to the register-file value.
  always_comb begin
    case (ForwardA_E)
      2'b01:   rd1_fwd = Result_W;
      2'b10:   rd1_fwd = alu_result_q;
      default: rd1_fwd = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   rd2_fwd = Result_W;
      2'b10:   rd2_fwd = alu_result_q;
      default: rd2_fwd = RD2_E;
    endcase
  end

  assign src_a = (op_E == OP_AUIPC) ? PC_E : rd1_fwd;
  assign src_b = ALUSrc_E ? ImmExt_E : rd2_fwd;

  logic [XLEN-1:0] a_uw;
  logic [5:0]      shamt;
  logic [4:0]      shamt_w;
  logic [31:0]     addw, subw, sllw, srlw, sraw;
  logic [XLEN-1:0] sra;
  logic            lt_s, lt_u;

  assign a_uw    = {32'b0, src_a[31:0]};
  assign shamt   = src_b[5:0];
  assign shamt_w = src_b[4:0];
  assign addw    = src_a[31:0] + src_b[31:0];
  assign subw    = src_a[31:0] - src_b[31:0];
  assign sllw    = src_a[31:0] << shamt_w;
  assign srlw    = src_a[31:0] >> shamt_w;
  assign sraw    = $unsigned($signed(src_a[31:0]) >>> shamt_w);
  assign sra     = $unsigned($signed(src_a) >>> shamt);
  assign lt_s    = $signed(src_a) < $signed(src_b);
  assign lt_u    = src_a < src_b;

  logic [XLEN-1:0] shadd    [1:3];
  logic [XLEN-1:0] shadd_uw [1:3];

  generate
    for (genvar gi = 1; gi <= 3; gi++) begin : g_shadd
      assign shadd[gi]    = (src_a << gi) + src_b;
      assign shadd_uw[gi] = (a_uw << gi) + src_b;
    end
  endgenerate

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  always_comb begin
    alu_result = '0;
    case (ALUControl_E)
      5'd0:  alu_result = src_a + src_b;
      5'd1:  alu_result = src_a - src_b;
      5'd2:  alu_result = src_a & src_b;
      5'd3:  alu_result = src_a | src_b;
      5'd4:  alu_result = src_a ^ src_b;
      5'd5:  alu_result = {{(XLEN-1){1'b0}}, lt_s};
      5'd6:  alu_result = {{(XLEN-1){1'b0}}, lt_u};
      5'd7:  alu_result = src_a << shamt;
      5'd8:  alu_result = src_a >> shamt;
      5'd9:  alu_result = sra;
      5'd10: alu_result = sext32(addw);
      5'd11: alu_result = sext32(subw);
      5'd12: alu_result = sext32(sllw);
      5'd13: alu_result = sext32(srlw);
      5'd14: alu_result = sext32(sraw);
      5'd15: alu_result = shadd[1];
      5'd16: alu_result = shadd[2];
      5'd17: alu_result = shadd[3];
      5'd18: alu_result = a_uw + src_b;
      5'd19: alu_result = shadd_uw[1];
      5'd20: alu_result = shadd_uw[2];
      5'd21: alu_result = shadd_uw[3];
      5'd22: alu_result = a_uw << shamt;
      5'd23: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  // Branch compare uses the forwarded register operands, never the immediate.
  always_comb begin
    branch_cond = 1'b0;
    case (funct3_E)
      3'b000: branch_cond = (rd1_fwd == rd2_fwd);
      3'b001: branch_cond = (rd1_fwd != rd2_fwd);
      3'b100: branch_cond = ($signed(rd1_fwd) < $signed(rd2_fwd));
      3'b101: branch_cond = ($signed(rd1_fwd) >= $signed(rd2_fwd));
      3'b110: branch_cond = (rd1_fwd < rd2_fwd);
      3'b111: branch_cond = (rd1_fwd >= rd2_fwd);
      default: branch_cond = 1'b0;
    endcase
  end

  logic [XLEN-1:0] jalr_sum;
  assign jalr_sum   = rd1_fwd + ImmExt_E;
  assign PCSrc_E    = Jump_E | (Branch_E & branch_cond);
  assign PCTarget_E = is_jalr_E ? {jalr_sum[XLEN-1:1], 1'b0} : (PC_E + ImmExt_E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      funct3_q     <= '0;
    end else if (flush_M) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      funct3_q     <= '0;
    end else if (!stall_M) begin
      alu_result_q <= alu_result;
      write_data_q <= rd2_fwd;
      pc_plus4_q   <= PC_E + 64'd4;
      rd_q         <= Rd_E;
      reg_write_q  <= RegWrite_E;
      mem_write_q  <= MemWrite_E;
      result_src_q <= ResultSrc_E;
      funct3_q     <= funct3_E;
    end
  end

  assign ALUResult_M = alu_result_q;
  assign WriteData_M = write_data_q;
  assign PCPlus4_M   = pc_plus4_q;
  assign Rd_M        = rd_q;
  assign RegWrite_M  = reg_write_q;
  assign MemWrite_M  = mem_write_q;
  assign ResultSrc_M = result_src_q;
  assign funct3_M    = funct3_q;

`ifdef EX_PERF_CNT_EN
  logic [31:0] br_count_q, br_taken_q;
  logic        br_event;

  assign br_event = Branch_E & ~stall_M & ~flush_M;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q <= '0;
      br_taken_q <= '0;
    end else if (perf_clr) begin
      br_count_q <= '0;
      br_taken_q <= '0;
    end else if (br_event) begin
      br_count_q <= br_count_q + 32'd1;
      if (branch_cond) br_taken_q <= br_taken_q + 32'd1;
    end
  end

  assign br_count       = br_count_q;
  assign br_taken_count = br_taken_q;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; exercises EX_PERF_CNT_EN counters when that macro is defined.
module tb_ex_stage;

  logic        clk, rst_n, stall_M, flush_M;
  logic [63:0] RD1_E, RD2_E, PC_E, ImmExt_E, Result_W;
  logic [4:0]  Rd_E, ALUControl_E;
  logic [6:0]  op_E;
  logic        RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E, is_jalr_E;
  logic [1:0]  ResultSrc_E, ForwardA_E, ForwardB_E;
  logic [2:0]  funct3_E;
  logic        PCSrc_E;
  logic [63:0] PCTarget_E, ALUResult_M, WriteData_M, PCPlus4_M;
  logic [4:0]  Rd_M;
  logic        RegWrite_M, MemWrite_M;
  logic [1:0]  ResultSrc_M;
  logic [2:0]  funct3_M;
`ifdef EX_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] br_count, br_taken_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_M(stall_M), .flush_M(flush_M),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .PC_E(PC_E), .ImmExt_E(ImmExt_E),
    .Rd_E(Rd_E), .op_E(op_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
    .ALUSrc_E(ALUSrc_E), .Branch_E(Branch_E), .Jump_E(Jump_E), .is_jalr_E(is_jalr_E),
    .ResultSrc_E(ResultSrc_E), .ALUControl_E(ALUControl_E), .funct3_E(funct3_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Result_W(Result_W),
`ifdef EX_PERF_CNT_EN
    .perf_clr(perf_clr), .br_count(br_count), .br_taken_count(br_taken_count),
`endif
    .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E), .ALUResult_M(ALUResult_M),
    .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M), .Rd_M(Rd_M),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .funct3_M(funct3_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      $display("[%0t] %s = %h", $time, tag, obs);
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_M = 1'b0; flush_M = 1'b0;
    RD1_E = '0; RD2_E = '0; PC_E = '0; ImmExt_E = '0; Result_W = '0;
    Rd_E = '0; ALUControl_E = '0; op_E = 7'b0110011;
    RegWrite_E = 1'b0; MemWrite_E = 1'b0; ALUSrc_E = 1'b0; Branch_E = 1'b0;
    Jump_E = 1'b0; is_jalr_E = 1'b0; ResultSrc_E = '0; funct3_E = '0;
    ForwardA_E = '0; ForwardB_E = '0;
`ifdef EX_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    #2;
    check("reset ALUResult_M", ALUResult_M, 64'h0);
    check("reset PCPlus4_M", PCPlus4_M, 64'h0);
    check("reset RegWrite_M", {63'b0, RegWrite_M}, 64'h0);
    #5 rst_n = 1'b1;

    // SH3ADD: (2<<3)+0x10
    ALUControl_E = 5'd17; RD1_E = 64'h2; ImmExt_E = 64'h10; ALUSrc_E = 1'b1;
    PC_E = 64'h100; Rd_E = 5'd5; RegWrite_E = 1'b1; ResultSrc_E = 2'b01; funct3_E = 3'b011;
    tick();
    check("sh3add ALUResult_M", ALUResult_M, 64'h20);
    check("sh3add PCPlus4_M", PCPlus4_M, 64'h104);
    check("sh3add Rd_M", {59'b0, Rd_M}, 64'd5);
    check("sh3add RegWrite_M", {63'b0, RegWrite_M}, 64'd1);
    check("sh3add ResultSrc_M", {62'b0, ResultSrc_M}, 64'd1);
    check("sh3add funct3_M", {61'b0, funct3_M}, 64'd3);

    // ADDW overflow sign-extends bit 31
    ALUControl_E = 5'd10; ALUSrc_E = 1'b0; RD1_E = 64'h7FFF_FFFF; RD2_E = 64'h1;
    ResultSrc_E = 2'b00; funct3_E = 3'b000;
    tick();
    check("addw ALUResult_M", ALUResult_M, 64'hFFFF_FFFF_8000_0000);
    check("addw WriteData_M", WriteData_M, 64'h1);

    ALUControl_E = 5'd14; RD1_E = 64'h8000_0000; RD2_E = 64'h4;
    tick();
    check("sraw ALUResult_M", ALUResult_M, 64'hFFFF_FFFF_F800_0000);

    ALUControl_E = 5'd1; RD1_E = 64'h0; RD2_E = 64'h1;
    tick();
    check("sub wrap ALUResult_M", ALUResult_M, 64'hFFFF_FFFF_FFFF_FFFF);

    ALUControl_E = 5'd22; RD1_E = 64'hFFFF_FFFF_0000_0001; ImmExt_E = 64'h20; ALUSrc_E = 1'b1;
    tick();
    check("slli.uw ALUResult_M", ALUResult_M, 64'h0000_0001_0000_0000);

    ALUControl_E = 5'd25; RD1_E = 64'h1234;
    tick();
    check("aluctl25 ALUResult_M", ALUResult_M, 64'h0);

    // AUIPC: PC replaces SrcA
    op_E = 7'b0010111; ALUControl_E = 5'd0; PC_E = 64'h1000; ImmExt_E = 64'h2000; RD1_E = 64'h7;
    tick();
    check("auipc ALUResult_M", ALUResult_M, 64'h3000);
    op_E = 7'b0110011;

    // Forwarding from the EM register and from writeback
    ALUControl_E = 5'd23; ImmExt_E = 64'h55;
    tick();
    check("passb ALUResult_M", ALUResult_M, 64'h55);
    ForwardA_E = 2'b10; RD1_E = 64'h11; ALUControl_E = 5'd0; ImmExt_E = 64'h1;
    tick();
    check("fwdA=10 ALUResult_M", ALUResult_M, 64'h56);
    ForwardA_E = 2'b00; ForwardB_E = 2'b01; Result_W = 64'hAB; RD2_E = 64'h9; MemWrite_E = 1'b1;
    tick();
    check("fwdB=01 WriteData_M", WriteData_M, 64'hAB);
    check("fwdB=01 MemWrite_M", {63'b0, MemWrite_M}, 64'd1);
    ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 64'h3; RD2_E = 64'h9; MemWrite_E = 1'b0;
    tick();
    check("fwdA=11 ALUResult_M", ALUResult_M, 64'h4);
    check("fwdB=11 WriteData_M", WriteData_M, 64'h9);
    ForwardA_E = 2'b00; ForwardB_E = 2'b00;

    // Branches (combinational)
    Branch_E = 1'b1; funct3_E = 3'b100; RD1_E = 64'hFFFF_FFFF_FFFF_FFFF; RD2_E = 64'h1;
    PC_E = 64'h2000; ImmExt_E = 64'h40; ALUSrc_E = 1'b0;
    #1;
    check("blt PCSrc_E", {63'b0, PCSrc_E}, 64'd1);
    check("blt PCTarget_E", PCTarget_E, 64'h2040);
    funct3_E = 3'b110; #1;
    check("bltu PCSrc_E", {63'b0, PCSrc_E}, 64'd0);
    funct3_E = 3'b010; #1;
    check("f3=010 PCSrc_E", {63'b0, PCSrc_E}, 64'd0);
    funct3_E = 3'b001; RD1_E = 64'h5; RD2_E = 64'h5; ALUSrc_E = 1'b1; ImmExt_E = 64'h8; #1;
    check("bne uses RD2 PCSrc_E", {63'b0, PCSrc_E}, 64'd0);
    funct3_E = 3'b101; RD1_E = 64'h1; RD2_E = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    check("bge PCSrc_E", {63'b0, PCSrc_E}, 64'd1);
    Branch_E = 1'b0;

    // JALR clears bit 0 of the target
    Jump_E = 1'b1; is_jalr_E = 1'b1; RD1_E = 64'h1001; ImmExt_E = 64'h4; PC_E = 64'h3000;
    ALUControl_E = 5'd0; funct3_E = 3'b000;
    #1;
    check("jalr PCTarget_E", PCTarget_E, 64'h1004);
    check("jalr PCSrc_E", {63'b0, PCSrc_E}, 64'd1);
    tick();
    check("jalr PCPlus4_M", PCPlus4_M, 64'h3004);
    Jump_E = 1'b0; is_jalr_E = 1'b0;

    // Stall holds, flush beats stall
    ALUControl_E = 5'd23; ALUSrc_E = 1'b1; ImmExt_E = 64'h33; Rd_E = 5'd7; RegWrite_E = 1'b1;
    tick();
    check("load ALUResult_M", ALUResult_M, 64'h33);
    stall_M = 1'b1; ImmExt_E = 64'h77; Rd_E = 5'd9; PC_E = 64'h5000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall ALUResult_M", ALUResult_M, 64'h33);
      check("stall Rd_M", {59'b0, Rd_M}, 64'd7);
    end
    // PC redirect stays live while stalled
    Jump_E = 1'b1; ImmExt_E = 64'h10; #1;
    check("stall PCTarget_E", PCTarget_E, 64'h5010);
    Jump_E = 1'b0;
    flush_M = 1'b1;
    tick();
    check("flush ALUResult_M", ALUResult_M, 64'h0);
    check("flush RegWrite_M", {63'b0, RegWrite_M}, 64'd0);
    check("flush PCPlus4_M", PCPlus4_M, 64'h0);
    check("flush Rd_M", {59'b0, Rd_M}, 64'd0);
    flush_M = 1'b0; stall_M = 1'b0;

    // Asynchronous reset mid-stall, then reload
    ImmExt_E = 64'h44;
    tick();
    check("preload ALUResult_M", ALUResult_M, 64'h44);
    stall_M = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async reset ALUResult_M", ALUResult_M, 64'h0);
    check("async reset RegWrite_M", {63'b0, RegWrite_M}, 64'd0);
    #2 rst_n = 1'b1; stall_M = 1'b0; ImmExt_E = 64'h99; Rd_E = 5'd0;
    tick();
    check("post-reset ALUResult_M", ALUResult_M, 64'h99);
    check("x0 RegWrite_M", {63'b0, RegWrite_M}, 64'd1);

`ifdef EX_PERF_CNT_EN
    perf_clr = 1'b1; Branch_E = 1'b1;
    tick();
    check("perf_clr br_count", {32'b0, br_count}, 64'd0);
    perf_clr = 1'b0; funct3_E = 3'b000; ALUSrc_E = 1'b0;
    for (int i = 0; i < 5; i++) begin
      RD1_E = 64'h10;
      RD2_E = (i == 1 || i == 3) ? 64'h10 : 64'h20;
      tick();
    end
    Branch_E = 1'b0;
    tick();
    check("br_count", {32'b0, br_count}, 64'd5);
    check("br_taken_count", {32'b0, br_taken_count}, 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
